// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a per-entry N-bit saturating
//   counter. It predicts the next fetch PC combinationally from pc_i and
//   takes one training write per cycle from the resolve stage.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-high reset (table and statistics)
//   start_i         enable; low freezes training and statistics (lookups live)
//   flush_i         synchronous invalidate of every entry; beats an update
//   pc_i            fetch PC to predict
//   pred_taken_o    predicted taken (hit and counter MSB set)
//   pred_target_o   stored target when predicted taken, else pc_i + 4
//   upd_valid_i     a resolved branch is presented this cycle
//   upd_pc_i        PC of the resolved branch
//   upd_taken_i     resolved outcome
//   upd_target_i    resolved taken target
//   upd_mispred_i   resolve stage flagged a mispredict
//   stat_branches_o saturating count of accepted updates
//   stat_mispred_o  saturating count of accepted updates flagged mispredicted
//
// STAT_W sets the internal width of the statistics counters (1..32). They
// saturate at all-ones of that width and are zero-extended onto the 32-bit
// ports, so the default of 32 saturates at 0xFFFFFFFF.

module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Weakly-taken is the MSB alone; weakly-not-taken sits one below it.
  // With CNT_W = 1 these become 1 and 0, giving a last-outcome bit.
  localparam logic [CNT_W-1:0] CTR_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CTR_WNT = CTR_WT - CNT_W'(1);

  // Flattened view of the table, assembled from the per-entry registers.
  logic [ENTRIES-1:0]             valid_vec;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_vec;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_vec;
  logic [ENTRIES-1:0][CNT_W-1:0]  ctr_vec;

  // ------------------------------------------------------------------
  // Lookup
  // ------------------------------------------------------------------
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx = pc_i[IDX_W+1:2];
  assign look_tag = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign look_hit = valid_vec[look_idx] && (tag_vec[look_idx] == look_tag);

  // No bypass from a same-cycle update: the registered entry is what a
  // lookup sees, so a fresh allocation shows up one cycle later.
  assign pred_taken_o  = look_hit && ctr_vec[look_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_vec[look_idx]
                                      : pc_i + ADDR_W'(4);

  // ------------------------------------------------------------------
  // Training
  // ------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_accept;

  assign upd_idx    = upd_pc_i[IDX_W+1:2];
  assign upd_tag    = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit    = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
  // Flush wins over a coincident update; that update is neither applied
  // nor counted.
  assign upd_accept = upd_valid_i && start_i && !flush_i;

  // Only the index and tag fields of either PC are used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i, upd_pc_i};

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic              valid_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [ADDR_W-1:0] target_reg;
    logic [CNT_W-1:0]  ctr_reg;
    logic              sel;

    assign sel = upd_accept && (upd_idx == IDX_W'(gi));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_reg  <= 1'b0;
        tag_reg    <= '0;
        target_reg <= '0;
        ctr_reg    <= CTR_WNT;
      end else if (flush_i) begin
        // Flush only drops valid; counter and target history survive.
        valid_reg <= 1'b0;
      end else if (sel) begin
        if (upd_hit) begin
          if (upd_taken_i) begin
            if (ctr_reg != CTR_MAX) ctr_reg <= ctr_reg + CNT_W'(1);
            target_reg <= upd_target_i;
          end else if (ctr_reg != '0) begin
            ctr_reg <= ctr_reg - CNT_W'(1);
          end
        end else if (upd_taken_i) begin
          // Taken miss replaces whatever occupied this index.
          valid_reg  <= 1'b1;
          tag_reg    <= upd_tag;
          target_reg <= upd_target_i;
          ctr_reg    <= CTR_WT;
        end
        // Not-taken miss leaves the entry alone.
      end
    end

    assign valid_vec[gi]  = valid_reg;
    assign tag_vec[gi]    = tag_reg;
    assign target_vec[gi] = target_reg;
    assign ctr_vec[gi]    = ctr_reg;
  end

  // ------------------------------------------------------------------
  // Statistics
  // ------------------------------------------------------------------
  logic [STAT_W-1:0] stat_branches_reg;
  logic [STAT_W-1:0] stat_mispred_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else if (upd_accept) begin
      if (stat_branches_reg != {STAT_W{1'b1}})
        stat_branches_reg <= stat_branches_reg + STAT_W'(1);
      if (upd_mispred_i && (stat_mispred_reg != {STAT_W{1'b1}}))
        stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
    end
  end

  assign stat_branches_o = 32'(stat_branches_reg);
  assign stat_mispred_o  = 32'(stat_mispred_reg);

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor that replaces the static "branch AND zero" PC selection with a fetch-time prediction. It is a direct-mapped branch target buffer in which each entry holds a tag, a target and an N-bit saturating counter. Lookup is combinational from the fetch PC. Training happens one write per cycle from the resolve stage. The block sits beside PC and Instruction_Memory and drives the PC-select mux; the resolve stage feeds it outcomes.

Parameters:
ADDR_W, 32, PC and target width
ENTRIES, 64, number of BTB entries; power of two, >= 2
CNT_W, 2, saturating counter width; >= 1
TAG_W, 8, tag width; IDX_W + 2 + TAG_W <= ADDR_W, where IDX_W = log2(ENTRIES)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  enable; when low, updates and statistics are frozen and lookups still respond
flush_i  in  1  synchronous invalidate of all entries
pc_i  in  ADDR_W  fetch PC to predict
pred_taken_o  out  1  predicted taken
pred_target_o  out  ADDR_W  predicted next PC
upd_valid_i  in  1  resolved branch present this cycle
upd_pc_i  in  ADDR_W  PC of the resolved branch
upd_taken_i  in  1  actual outcome
upd_target_i  in  ADDR_W  actual taken target
upd_mispred_i  in  1  resolve stage flagged a mispredict
stat_branches_o  out  32  count of accepted updates
stat_mispred_o  out  32  count of accepted updates with upd_mispred_i set

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Bits [1:0] are ignored.
- Per entry: valid (1b), tag, target (ADDR_W), ctr (CNT_W).
- Reset (async, while rst_i high):
  - all valid = 0, ctr = WNT, where WNT = 2^(CNT_W-1) - 1; target = 0, tag = 0.
  - Both stat counters = 0.
  - Outputs follow the lookup rule with every entry a miss: pred_taken_o = 0, pred_target_o = pc_i + 4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - pred_taken_o = hit and ctr[idx] MSB.
  - pred_target_o = target[idx] if pred_taken_o, else pc_i + 4 (mod 2^ADDR_W, wraps at the top of the address space).
- Update, on the clock edge when upd_valid_i and start_i are high and flush_i is low:
  - Hit, taken: ctr = min(ctr + 1, 2^CNT_W - 1); target = upd_target_i.
  - Hit, not taken: ctr = max(ctr - 1, 0); target unchanged.
  - Miss, taken: allocate (overwrites any prior occupant): valid = 1, tag = upd tag, target = upd_target_i, ctr = WT, where WT = 2^(CNT_W-1).
  - Miss, not taken: no state change.
- CNT_W = 1: WNT = 0, WT = 1, and the counter behaves as a last-outcome bit.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry (no bypass). The new value is visible next cycle.
- flush_i: on the edge, all valid = 0. Ctr and target are left unchanged. Flush has priority over a simultaneous update; that update is dropped and not counted.
- Statistics, on each accepted update:
  - stat_branches_o += 1.
  - stat_mispred_o += 1 if upd_mispred_i.
  - Both saturate at 0xFFFFFFFF (no wrap).
- start_i low: no table or statistics change. flush_i is still honoured.
- Reset asserted mid-operation: the table and statistics clear immediately, without waiting for a clock edge.

Test Plan:
- Reset, pc_i=0x00000040 -> pred_taken_o=0, pred_target_o=0x00000044, both stats=0.
- ENTRIES=64, CNT_W=2: update pc=0x100 taken target=0x80 -> next cycle, pc_i=0x100 gives pred_taken_o=1, pred_target_o=0x80, ctr=2. Two more taken updates -> ctr saturates at 3. Three not-taken updates -> ctr=0 and pred_taken_o=0, pred_target_o=0x104.
- Aliasing: train pc=0x100 taken, then update pc=0x200 taken target=0x40 (same index, different tag) -> pc_i=0x100 misses (0x104); pc_i=0x200 predicts 0x40.
- Same-cycle: pc_i=0x300 while update 0x300 allocates -> that cycle pred_taken_o=0; next cycle pred_taken_o=1.
- flush_i together with upd_valid_i -> all entries miss, stat_branches_o unchanged. With start_i=0, 5 updates -> no stat or table change.
- Force stat_mispred_o to 0xFFFFFFFF via 2^32 updates, or with a reduced-width bench override -> a further mispredict update holds 0xFFFFFFFF. Assert rst_i between clock edges -> stats read 0 before the next edge.
